// File: rtl/ofm_reader_if.sv
// ofm_reader_if: command, OFM bank and byte-stream signals of ofm_reader.
// master = the read engine, slave = its environment (sequencer, bank, loader).
interface ofm_reader_if #(
  parameter int ADDR_W = 8,
  parameter int LEN_W  = 8
);
  logic              start;
  logic [ADDR_W-1:0] base_addr;
  logic [LEN_W-1:0]  word_cnt;
  logic              busy;
  logic              done;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_wren;
  logic [31:0]       mem_rdata;
  logic [7:0]        out_data;
  logic              out_valid;
  logic              out_ready;
  logic              out_last;

  modport master (
    input  start, base_addr, word_cnt, mem_rdata, out_ready,
    output busy, done, mem_addr, mem_wren, out_data, out_valid, out_last
  );

  modport slave (
    output start, base_addr, word_cnt, mem_rdata, out_ready,
    input  busy, done, mem_addr, mem_wren, out_data, out_valid, out_last
  );
endinterface

// File: rtl/ofm_reader.sv
// ofm_reader: reads a contiguous run of 32-bit words from one OFM bank and
// streams them LSB byte first over valid/ready, with a done pulse at the end.
// Optional macro OFM_RD_RELU_EN: bytes with bit 7 set are streamed as 0x00.
module ofm_reader #(
  parameter int ADDR_W = 8,
  parameter int LEN_W  = 8
) (
  input  logic          clk,
  input  logic          rst,
  ofm_reader_if.master  bus
);

  typedef enum logic [1:0] {IDLE, FETCH, SEND, DONE} state_t;

  state_t            state;
  logic [ADDR_W-1:0] addr_q;
  logic [LEN_W-1:0]  remaining;
  logic [31:0]       word_reg;
  logic [1:0]        byte_idx;
  logic [7:0]        byte_sel;
  logic [7:0]        byte_out;
  logic              last_word;
  logic              beat;

  assign last_word = (remaining == LEN_W'(1));
  assign beat      = (state == SEND) && bus.out_ready;

  // Control FSM plus run counters; only FETCH touches the bank word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      addr_q    <= '0;
      remaining <= '0;
      word_reg  <= '0;
      byte_idx  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            addr_q    <= bus.base_addr;
            remaining <= bus.word_cnt;
            state     <= (bus.word_cnt == '0) ? DONE : FETCH;
          end
        end
        FETCH: begin
          word_reg <= bus.mem_rdata;
          byte_idx <= 2'd0;
          state    <= SEND;
        end
        SEND: begin
          if (beat) begin
            if (byte_idx != 2'd3) begin
              byte_idx <= byte_idx + 2'd1;
            end else if (!last_word) begin
              remaining <= remaining - LEN_W'(1);
              addr_q    <= addr_q + ADDR_W'(1);
              state     <= FETCH;
            end else begin
              state <= DONE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Byte lane select from the captured word, LSB first.
  always_comb begin
    byte_sel = word_reg[7:0];
    case (byte_idx)
      2'd0: byte_sel = word_reg[7:0];
      2'd1: byte_sel = word_reg[15:8];
      2'd2: byte_sel = word_reg[23:16];
      2'd3: byte_sel = word_reg[31:24];
      default: byte_sel = word_reg[7:0];
    endcase
  end

  // Optional ReLU on the outgoing byte; purely combinational, no extra latency.
  always_comb begin
`ifdef OFM_RD_RELU_EN
    byte_out = byte_sel[7] ? 8'h00 : byte_sel;
`else
    byte_out = byte_sel;
`endif
  end

  // Outputs decode straight from registered state, so they hold during stalls.
  assign bus.busy      = (state == FETCH) || (state == SEND);
  assign bus.done      = (state == DONE);
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wren  = 1'b0;
  assign bus.out_valid = (state == SEND);
  assign bus.out_data  = (state == SEND) ? byte_out : 8'h00;
  assign bus.out_last  = (state == SEND) && (byte_idx == 2'd3) && last_word;

endmodule
